// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, IF/ID output register,
// decode handshake and redirect inputs.
// master = fetch_unit, slave = environment (memory / decode / branch unit).
interface fetch_unit_if;
   logic [15:0] im_pc;
   logic [15:0] im_instr;
   logic        id_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] fetch_count;
   logic        halted;

   modport master (
      output im_pc,
      input  im_instr,
      input  id_ready,
      input  redirect_valid,
      input  redirect_pc,
      output if_valid,
      output if_instr,
      output if_pc,
      output fetch_count,
      output halted
   );

   modport slave (
      input  im_pc,
      output im_instr,
      output id_ready,
      output redirect_valid,
      output redirect_pc,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      input  fetch_count,
      input  halted
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator for the 16-b core. Drives the PC into a
// combinational word ROM and captures the returned word into the IF/ID
// register, with valid/ready handshake toward decode, redirects, PC wrap
// and a saturating count of accepted instructions.
// Optional macro FETCH_HALT_DETECT_EN: stop fetching after an opcode-F word.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          IM_WORDS = 16,
   parameter int          PC_STEP  = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   // Byte-address mask covering the ROM; bit 0 always cleared.
   localparam logic [15:0] PC_MASK = 16'(2 * IM_WORDS - 1) & 16'hFFFE;
   localparam logic [15:0] PC_RST  = RESET_PC & PC_MASK;
   localparam logic [15:0] STEP    = 16'(PC_STEP);

   logic [15:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [15:0] if_instr_q, if_instr_d;
   logic [15:0] if_pc_q, if_pc_d;
   logic [15:0] fetch_count_q, fetch_count_d;
   logic        run;
   logic        adv;

`ifdef FETCH_HALT_DETECT_EN
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0] state_q, state_d;
   logic       halted_q, halted_d;

   assign run        = (state_q == ST_RUN);
   assign bus.halted = halted_q;
`else
   assign run        = 1'b1;
   assign bus.halted = 1'b0;
`endif

   assign adv = (!if_valid_q || bus.id_ready) && run;

   // Next-state: redirect beats everything, then advance, else hold.
   always_comb begin
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
`ifdef FETCH_HALT_DETECT_EN
      state_d    = state_q;
      halted_d   = halted_q;
`endif
      if (bus.redirect_valid) begin
         // Flush the IF/ID word; target shows up one cycle later.
         pc_d       = bus.redirect_pc & PC_MASK;
         if_valid_d = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
         state_d    = ST_RUN;
         halted_d   = 1'b0;
`endif
      end else if (adv) begin
         if_instr_d = bus.im_instr;
         if_pc_d    = pc_q;
         if_valid_d = 1'b1;
         pc_d       = (pc_q + STEP) & PC_MASK;
`ifdef FETCH_HALT_DETECT_EN
         if (bus.im_instr[15:12] == 4'hF) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
         end
`endif
      end
`ifdef FETCH_HALT_DETECT_EN
      else if (if_valid_q && bus.id_ready) begin
         // Halted: the HALT word drains and nothing refills the register.
         if_valid_d = 1'b0;
      end
`endif
   end

   // Accepted-instruction counter; a word flushed by a redirect is not counted.
   always_comb begin
      fetch_count_d = fetch_count_q;
      if (if_valid_q && bus.id_ready && !bus.redirect_valid &&
          fetch_count_q != 16'hFFFF)
         fetch_count_d = fetch_count_q + 16'd1;
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= PC_RST;
         if_valid_q    <= 1'b0;
         if_instr_q    <= 16'h0000;
         if_pc_q       <= 16'h0000;
         fetch_count_q <= 16'h0000;
      end else begin
         pc_q          <= pc_d;
         if_valid_q    <= if_valid_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

`ifdef FETCH_HALT_DETECT_EN
   // Halt FSM registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end
`endif

   assign bus.im_pc       = pc_q;
   assign bus.if_valid    = if_valid_q;
   assign bus.if_instr    = if_instr_q;
   assign bus.if_pc       = if_pc_q;
   assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the 16-b RISC core; drives the PC into the instruction memory and captures the returned word.
- The instruction memory is a combinational, word-addressed ROM of IM_WORDS x 16 b, indexed by PC[4:1].
- Holds the IF/ID register toward decode with a valid/ready handshake, and handles stalls, branch/jump redirects, PC wrap-around and a fetch counter.

Parameters:
- RESET_PC, 16'h0000, byte address fetched first after reset; bit 0 ignored.
- IM_WORDS, 16, instruction-memory depth in words; power of 2, range 2..32768.
- PC_STEP, 2, byte increment per sequential fetch; one 16-b word.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- im_pc  out  16  fetch address to the instruction memory; equals pc_q.
- im_instr  in  16  instruction word returned combinationally for im_pc.
- id_ready  in  1  decode accepts the IF/ID register this cycle.
- redirect_valid  in  1  branch/jump taken; load a new PC.
- redirect_pc  in  16  target byte address.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_instr  out  16  fetched instruction.
- if_pc  out  16  byte address of if_instr.
- fetch_count  out  16  number of instructions accepted by decode; saturating.
- halted  out  1  fetch stopped on HALT (see Optional Feature).

Behaviour:
- Reset values (async, rst_n=0):
  - pc_q=RESET_PC & PC_MASK, where PC_MASK = 2*IM_WORDS-1 with bit 0 cleared.
  - if_valid=0, if_instr=16'h0000, if_pc=16'h0000, fetch_count=0, halted=0, FSM=RUN.
- Leaving reset: the first rising edge with rst_n=1 captures mem[RESET_PC>>1]; if_valid=1 after that edge. Latency is 1 cycle from PC to IF/ID.
- Advance condition: adv = (!if_valid || id_ready) and FSM=RUN.
- On adv with no redirect:
  - if_instr<=im_instr, if_pc<=pc_q, if_valid<=1.
  - pc_q<=(pc_q+PC_STEP) & PC_MASK. With IM_WORDS=16, PC 16'h001E wraps to 16'h0000.
- Stall: if_valid=1 and id_ready=0 -> if_instr, if_pc, if_valid and pc_q all hold. im_pc stays stable.
- Redirect has highest priority and applies in any state, including stall:
  - pc_q<=redirect_pc & PC_MASK. Bit 0 and out-of-range upper bits are dropped.
  - if_valid<=0 (flush), FSM<=RUN.
  - The target instruction appears in IF/ID one cycle later. This gives exactly one bubble.
- fetch_count increments when if_valid && id_ready && !redirect_valid. It saturates at 16'hFFFF and never wraps.
- A handshake completing in the same cycle as a redirect is not counted, because the flushed word is discarded.
- FSM states:
  - RUN: normal fetch.
  - HALT: only with the Optional Feature.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - When an advance captures im_instr[15:12]==4'hF (HALT), FSM<=HALT and halted<=1.
  - The HALT word itself is presented with if_valid=1 and handshakes normally. pc_q holds at the address after HALT.
  - While in HALT: no further captures. Once the HALT word is consumed, if_valid falls to 0 and stays 0.
  - Only a redirect or reset exits HALT; either clears halted.
- Undefined: opcode 4'hF is an ordinary instruction, the FSM never leaves RUN, and halted is tied to 0.

Test Plan:
- Straight line: reset, id_ready=1, mem[i]=16'h1000+i -> if_pc 0,2,4,... with if_instr 16'h1000,16'h1001,...; fetch_count=5 after 5 accepts.
- Wrap: run 17 fetches with IM_WORDS=16 -> the 16th has if_pc=16'h001E, the 17th has if_pc=16'h0000 and if_instr=mem[0].
- Stall: drop id_ready for 3 cycles while if_pc=16'h0006 -> if_pc/if_instr/im_pc frozen and fetch_count unchanged; on release the next word has if_pc=16'h0008.
- Redirect during stall: redirect_valid=1, redirect_pc=16'h0015, id_ready=0 -> next cycle if_valid=0; following cycle if_pc=16'h0014 and if_instr=mem[10]; fetch_count not incremented.
- Async reset mid-run: pull rst_n low between clock edges at if_pc=16'h000C -> if_valid=0 and fetch_count=0 immediately; after release, refetch starts from 16'h0000.
- Halt (FETCH_HALT_DETECT_EN defined): mem[3]=16'hF000 -> HALT word is delivered, then halted=1, if_valid=0 and im_pc=16'h0008 held for 10 cycles; redirect_pc=16'h0000 resumes fetch and clears halted.
